// File: rtl/cmp_harness_pkg.sv
// Shared definitions for serial compressor evaluation harnesses: the
// frame state machine encoding and counter width helpers.
package cmp_harness_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMMIT,
    WAIT,
    CAPTURE,
    DRAIN
  } state_t;

  // Width needed to hold a count of 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/result_serializer.sv
// Parallel-loads a DST_W-bit result and shifts it out LSB first, flagging
// every valid bit and pulsing done alongside the final one.
module result_serializer
  import cmp_harness_pkg::*;
#(
  parameter int DST_W = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DST_W-1:0] data,
  output logic             res_out,
  output logic             res_valid,
  output logic             done
);

  localparam int              CW   = cnt_w(DST_W);
  localparam logic [CW-1:0]   LAST = CW'(DST_W - 1);

  logic [DST_W-1:0] sreg;
  logic [DST_W-1:0] shifted;
  logic [CW-1:0]    left;

  assign shifted = sreg >> 1;

  // left counts the bits still to come after the one currently on res_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      left      <= '0;
      res_out   <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else if (load) begin
      sreg      <= data;
      left      <= LAST;
      res_out   <= data[0];
      res_valid <= 1'b1;
      done      <= (DST_W == 1);
    end else if (res_valid) begin
      if (left == '0) begin
        res_out   <= 1'b0;
        res_valid <= 1'b0;
        done      <= 1'b0;
      end else begin
        sreg    <= shifted;
        left    <= left - CW'(1);
        res_out <= shifted[0];
        done    <= (left == CW'(1));
      end
    end
  end

endmodule

// File: rtl/operand_shift_loader.sv
// Serial operand loader: fills a shadow bank bit-serially, commits it to the
// compressor operand bus, captures the result and drains it serially.
module operand_shift_loader
  import cmp_harness_pkg::*;
#(
  parameter int N_SRC   = 32,
  parameter int W       = 32,
  parameter int DST_W   = 37,
  parameter int CMP_LAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               shift_en,
  input  logic [N_SRC-1:0]   src_in,
  output logic [N_SRC*W-1:0] ops,
  input  logic [DST_W-1:0]   res_in,
  output logic               res_out,
  output logic               res_valid,
  output logic               done,
  output logic               busy
);

  localparam int            BW        = cnt_w(W);
  localparam int            LW        = cnt_w(CMP_LAT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
  localparam logic [LW-1:0] WAIT_LAST = LW'((CMP_LAT > 0) ? CMP_LAT - 1 : 0);

  state_t                     state, state_nx;
  logic [BW-1:0]              bit_cnt;
  logic [LW-1:0]              wait_cnt;
  logic [N_SRC-1:0][W-1:0]    shadow;
  logic                       accept;

  assign accept = (state == LOAD) && shift_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (accept && bit_cnt == BIT_LAST) state_nx = COMMIT;
      COMMIT:  state_nx = (CMP_LAT == 0) ? CAPTURE : WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_nx = CAPTURE;
      CAPTURE: state_nx = DRAIN;
      DRAIN:   if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == IDLE) bit_cnt <= '0;
      else if (accept)   bit_cnt <= bit_cnt + BW'(1);
      if (state == COMMIT)    wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + LW'(1);
    end
  end

  // One shift register per channel; the oldest accepted bit ends at the MSB.
  for (genvar ch = 0; ch < N_SRC; ch++) begin : g_chan
    logic [W-1:0] sh;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         sh <= '0;
      else if (accept) sh <= W'({sh, src_in[ch]});
    end
    assign shadow[ch] = sh;
  end

  // The operand bus only moves on COMMIT so the compressor never sees a partial load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  ops <= '0;
    else if (state == COMMIT) ops <= shadow;
  end

  result_serializer #(.DST_W(DST_W)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (state == CAPTURE),
    .data      (res_in),
    .res_out   (res_out),
    .res_valid (res_valid),
    .done      (done)
  );

endmodule

// File: tb/tb_operand_shift_loader.sv
// Scoreboard bench: two loaders (combinational and 2-cycle compressor) share
// stimulus; each frame's expected result and operands are queued for monitors.
module tb_operand_shift_loader;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          shift_en = 1'b0;
  logic [N-1:0]  src_in = '0;
  logic [N*W-1:0] ops0, ops2;
  logic [DW-1:0] res_in0;
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] res_in2 = '0;
  logic          ro0, rv0, dn0, bz0;
  logic          ro2, rv2, dn2, bz2;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]  qr0[$], qr2[$];
  logic [N*W-1:0] qo0[$], qo2[$];
  int             nb[2];
  logic [DW-1:0]  acc[2];
  logic [N-1:0]   pat[W];
  logic [N*W-1:0] prev_ops = '0;

  always #5 clk = ~clk;

  // Compressor stand-in: sum of the operand channels.
  function automatic logic [DW-1:0] chsum(input logic [N*W-1:0] o);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(o[i*W +: W]);
    return DW'(s);
  endfunction

  assign res_in0 = chsum(ops0);
  always @(posedge clk) begin
    d1      <= chsum(ops2);
    res_in2 <= d1;
  end

  operand_shift_loader #(.N_SRC(N), .W(W), .DST_W(DW), .CMP_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .shift_en(shift_en), .src_in(src_in),
    .ops(ops0), .res_in(res_in0), .res_out(ro0), .res_valid(rv0), .done(dn0), .busy(bz0));

  operand_shift_loader #(.N_SRC(N), .W(W), .DST_W(DW), .CMP_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .shift_en(shift_en), .src_in(src_in),
    .ops(ops2), .res_in(res_in2), .res_out(ro2), .res_valid(rv2), .done(dn2), .busy(bz2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic rv, input logic ro, input logic dn,
                     input logic [N*W-1:0] o);
    logic [DW-1:0]  er;
    logic [N*W-1:0] eo;
    int             sz;
    if (rv) begin
      if (nb[id] < DW) acc[id][nb[id]] = ro;
      nb[id]++;
    end
    if (dn) begin
      chk($sformatf("done_valid%0d", id), rv, 1);
      chk($sformatf("bits%0d", id), nb[id], DW);
      sz = (id == 0) ? qr0.size() : qr2.size();
      total++;
      if (sz == 0) begin
        bad++;
        $display("FAIL unexpected_done%0d: got done with %0d queued want >0", id, sz);
      end else begin
        if (id == 0) begin er = qr0.pop_front(); eo = qo0.pop_front(); end
        else begin er = qr2.pop_front(); eo = qo2.pop_front(); end
        chk($sformatf("result%0d", id), acc[id], er);
        chk($sformatf("ops%0d", id), o, eo);
      end
      nb[id] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      nb[0] = 0;
      nb[1] = 0;
    end else begin
      mon(0, rv0, ro0, dn0, ops0);
      mon(1, rv2, ro2, dn2, ops2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pat();
    for (int k = 0; k < W; k++) pat[k] = N'($urandom);
  endtask

  // One full frame from pat; toggle inserts a stall after every accepted bit,
  // early raises shift_en together with start (that bit must be dropped).
  task automatic frame(input bit toggle, input bit early);
    logic [N*W-1:0] eo;
    int v, s, acc_n, j, stalls, cyc, g;
    eo = '0;
    s  = 0;
    for (int c = 0; c < N; c++) begin
      v = 0;
      for (int k = 0; k < W; k++) v = v * 2 + int'(pat[k][c]);
      eo[c*W +: W] = W'(v);
      s += v;
    end
    qr0.push_back(DW'(s)); qr2.push_back(DW'(s));
    qo0.push_back(eo);     qo2.push_back(eo);

    start = 1'b1; shift_en = early; src_in = N'($urandom);
    step();
    start = 1'b0;
    cyc = 1; acc_n = 0; j = 0; stalls = 0;
    while (acc_n < W) begin
      if (toggle && (j % 2 == 1)) begin
        shift_en = 1'b0; src_in = N'($urandom); stalls++;
      end else begin
        shift_en = 1'b1; src_in = pat[acc_n]; acc_n++;
      end
      j++;
      step(); cyc++;
      chk("ops_hold0", ops0, prev_ops);
      chk("ops_hold2", ops2, prev_ops);
    end
    shift_en = 1'b0;
    step(); cyc++;
    chk("commit0", ops0, eo);
    chk("commit2", ops2, eo);
    prev_ops = eo;

    g = 0;
    while (!dn0 && g < 60) begin
      start = 1'($urandom_range(0, 1));
      step(); cyc++; g++;
    end
    start = 1'b0;
    chk("latency0", cyc, W + DW + 2 + stalls);
    step(); cyc++;
    chk("busy_drop0", bz0, 0);
    g = 0;
    while (!dn2 && g < 20) begin
      step(); cyc++; g++;
    end
    chk("latency2", cyc, W + DW + 4 + stalls);
    step();
    chk("busy_drop2", bz2, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ops0", ops0, 0);   chk("rst_ops2", ops2, 0);
    chk("rst_busy0", bz0, 0);   chk("rst_busy2", bz2, 0);
    chk("rst_valid0", rv0, 0);  chk("rst_done0", dn0, 0);
    chk("rst_out0", ro0, 0);    chk("rst_valid2", rv2, 0);
    rst = 1'b0;
    step();

    pat[0] = 4'b0011; pat[1] = 4'b0001; pat[2] = 4'b0101; pat[3] = 4'b0111;
    frame(1'b0, 1'b0);
    rand_pat();
    frame(1'b0, 1'b0);
    pat[0] = 4'b0011; pat[1] = 4'b0001; pat[2] = 4'b0101; pat[3] = 4'b0111;
    frame(1'b1, 1'b0);

    // abort a frame with reset after two accepted bits
    start = 1'b1; step(); start = 1'b0;
    shift_en = 1'b1; src_in = N'($urandom); step();
    src_in = N'($urandom); step();
    shift_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_ops0", ops0, 0);  chk("abort_ops2", ops2, 0);
    chk("abort_busy0", bz0, 0);  chk("abort_busy2", bz2, 0);
    prev_ops = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    for (int k = 0; k < W; k++) pat[k] = '1;
    frame(1'b0, 1'b0);

    rand_pat();
    frame(1'b0, 1'b1);
    for (int f = 0; f < 4; f++) begin
      rand_pat();
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) step();
    chk("queues_drained", qr0.size() + qr2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
